// File: rtl/pp_accum_sew_pkg.sv
// Shared types and helpers for the partial-product accumulator: element-width
// and FSM encodings plus a lane-aware 64-bit adder.
package pp_accum_sew_pkg;

  localparam int OUT_W          = 64;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10
  } sew_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Adds a and b as independent lanes of the given element width; carries
  // never cross a lane boundary.
  function automatic logic [OUT_W-1:0] lane_add(input logic [OUT_W-1:0] a,
                                                input logic [OUT_W-1:0] b,
                                                input logic [1:0]       sew);
    logic [OUT_W-1:0] r;
    r = '0;
    case (sew)
      SEW32: r = a + b;
      SEW16: begin
        r[31:0]  = a[31:0] + b[31:0];
        r[63:32] = a[63:32] + b[63:32];
      end
      default: begin
        for (int e = 0; e < 4; e++) r[16*e +: 16] = a[16*e +: 16] + b[16*e +: 16];
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pp_accum_sew_pp_weight_shift.sv
// Places one signed partial product at its byte weight inside the 64-bit
// packed result, according to its global index j and the element width.
module pp_weight_shift
  import pp_accum_sew_pkg::*;
#(
  parameter int PP_W = 18
) (
  input  logic [PP_W-1:0]  pp_i,
  input  logic [3:0]       j_i,
  input  logic [1:0]       sew_i,
  output logic [OUT_W-1:0] term_o
);

  logic [OUT_W-1:0] ext;
  logic [2:0]       rc32;
  logic [1:0]       rc16;
  logic [31:0]      lane32;

  assign ext    = {{(OUT_W-PP_W){pp_i[PP_W-1]}}, pp_i};
  // Byte weight is row+col; sew16 uses a 2x2 grid per element, sew32 a 4x4 grid.
  assign rc32   = {1'b0, j_i[3:2]} + {1'b0, j_i[1:0]};
  assign rc16   = {1'b0, j_i[1]} + {1'b0, j_i[0]};
  assign lane32 = ext[31:0] << {rc16, 3'b000};

  always_comb begin
    term_o = '0;
    case (sew_i)
      SEW32: term_o = ext << {rc32, 3'b000};
      SEW16: if (!j_i[3]) term_o = j_i[2] ? {lane32, 32'd0} : {32'd0, lane32};
      SEW8:  if (j_i < 4'(BYTES_PER_WORD)) term_o = {48'd0, ext[15:0]} << {j_i[1:0], 4'b0000};
      default: term_o = '0;
    endcase
  end

endmodule

// File: rtl/pp_accum_sew.sv
// Accumulates signed 9x9 partial products into packed 8/16/32-bit element
// products, with optional accumulation onto the previously delivered result.
module pp_accum_sew
  import pp_accum_sew_pkg::*;
#(
  parameter int NUM_MULT = 8,
  parameter int PP_W     = 18
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    sew,
  input  logic                          acc_en,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_MULT-1:0][PP_W-1:0] pp,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              result,
  output logic [1:0]                    state_o
);

  // Handshakes: a beat moves when in_valid && in_ready, a result when
  // out_valid && out_ready; result stays frozen while out_valid waits.
  state_e           state_q, state_d;
  logic [1:0]       sew_q, sew_d;
  logic             acc_en_q, acc_en_d;
  logic             beat_q, beat_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] result_q, result_d;

  logic [1:0]       eff_sew;
  logic             eff_acc;
  logic             beat_fire;
  logic             final_beat;
  logic [OUT_W-1:0] terms [NUM_MULT];
  logic [OUT_W-1:0] beat_sum;
  logic [OUT_W-1:0] base;
  logic [OUT_W-1:0] new_val;

  // Mode is taken live on the first beat and from the latched copy afterwards.
  assign eff_sew    = (state_q == IDLE) ? sew : sew_q;
  assign eff_acc    = (state_q == IDLE) ? acc_en : acc_en_q;
  assign in_ready   = (state_q != DONE);
  assign beat_fire  = in_valid && in_ready;
  assign final_beat = (eff_sew != SEW32) || (NUM_MULT >= 16) || beat_q;

  for (genvar k = 0; k < NUM_MULT; k++) begin : g_term
    logic [3:0] j;
    assign j = 4'(k) + (beat_q ? 4'(NUM_MULT) : 4'd0);
    pp_weight_shift #(.PP_W(PP_W)) u_ws (
      .pp_i   (pp[k]),
      .j_i    (j),
      .sew_i  (eff_sew),
      .term_o (terms[k])
    );
  end

  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < NUM_MULT; k++) beat_sum = lane_add(beat_sum, terms[k], eff_sew);
  end

  assign base    = (state_q == ACCUM) ? acc_q : (eff_acc ? result_q : '0);
  assign new_val = lane_add(base, beat_sum, eff_sew);

  always_comb begin
    state_d     = state_q;
    sew_d       = sew_q;
    acc_en_d    = acc_en_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    result_d    = result_q;
    case (state_q)
      IDLE: begin
        if (beat_fire) begin
          sew_d    = sew;
          acc_en_d = acc_en;
          if (sew == 2'b11) begin
            result_d    = '0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (final_beat) begin
            result_d    = new_val;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            acc_d   = new_val;
            beat_d  = 1'b1;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (beat_fire) begin
          if (final_beat) begin
            result_d    = new_val;
            out_valid_d = 1'b1;
            beat_d      = 1'b0;
            state_d     = DONE;
          end else begin
            acc_d  = new_val;
            beat_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          beat_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sew_q       <= 2'b00;
      acc_en_q    <= 1'b0;
      beat_q      <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      sew_q       <= sew_d;
      acc_en_q    <= acc_en_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pp_accum_sew.sv
// Bench for pp_accum_sew: two instances (NUM_MULT=8 and 16), operand-level
// reference model, expected-value queues popped by per-instance monitors.
module tb_pp_accum_sew;
  import pp_accum_sew_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]       sew8, st8, sew16, st16;
  logic             acc8, iv8, ir8, ov8, or8;
  logic             acc16, iv16, ir16, ov16, or16;
  logic [7:0][17:0] pp8;
  logic [15:0][17:0] pp16;
  logic [63:0]      res8, res16;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q8[$];
  logic [63:0] exp_q16[$];
  logic [63:0] prev8, prev16;
  logic [17:0] pps[16];
  int          bp_mode = 2;

  pp_accum_sew #(.NUM_MULT(8), .PP_W(18)) u_dut8 (
    .clk(clk), .reset(reset), .sew(sew8), .acc_en(acc8), .in_valid(iv8),
    .in_ready(ir8), .pp(pp8), .out_valid(ov8), .out_ready(or8),
    .result(res8), .state_o(st8)
  );

  pp_accum_sew #(.NUM_MULT(16), .PP_W(18)) u_dut16 (
    .clk(clk), .reset(reset), .sew(sew16), .acc_en(acc16), .in_valid(iv16),
    .in_ready(ir16), .pp(pp16), .out_valid(ov16), .out_ready(or16),
    .result(res16), .state_o(st16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [17:0] bprod(input logic [7:0] x, input bit xs,
                                        input logic [7:0] y, input bit ys);
    int xv, yv;
    xv = xs ? int'($signed(x)) : int'(x);
    yv = ys ? int'($signed(y)) : int'(y);
    return 18'(xv * yv);
  endfunction

  // Reference: element products from the operands themselves, plus optional prior value.
  function automatic logic [63:0] model(input logic [63:0] prev, input logic [1:0] s,
                                        input bit acc, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] bs, r;
    longint      p;
    int          q;
    bs = acc ? prev : 64'd0;
    r  = '0;
    case (s)
      2'b10: begin
        p = longint'($signed(a)) * longint'($signed(b));
        r = bs + 64'(p);
      end
      2'b01: for (int e = 0; e < 2; e++) begin
        q = int'($signed(a[16*e +: 16])) * int'($signed(b[16*e +: 16]));
        r[32*e +: 32] = bs[32*e +: 32] + 32'(q);
      end
      2'b00: for (int e = 0; e < 4; e++) begin
        q = int'($signed(a[8*e +: 8])) * int'($signed(b[8*e +: 8]));
        r[16*e +: 16] = bs[16*e +: 16] + 16'(q);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic build_pps(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 16; i++) pps[i] = 18'($urandom);
    case (s)
      2'b10: for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          pps[4*r+c] = bprod(a[8*c +: 8], c == 3, b[8*r +: 8], r == 3);
      2'b01: for (int e = 0; e < 2; e++)
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++)
            pps[4*e+2*r+c] = bprod(a[16*e+8*c +: 8], c == 1, b[16*e+8*r +: 8], r == 1);
      2'b00: for (int e = 0; e < 4; e++) pps[e] = bprod(a[8*e +: 8], 1'b1, b[8*e +: 8], 1'b1);
      default: ;
    endcase
  endtask

  task automatic send8(input logic [1:0] s, input bit a, input int first, input bit fin);
    int n;
    sew8 = s;
    acc8 = a;
    for (int k = 0; k < 8; k++) pp8[k] = pps[first+k];
    iv8 = 1'b1;
    n = 0;
    while (!ir8 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ir8) check("in_ready8_timeout", {63'd0, ir8}, 64'd1);
    @(posedge clk); #1;
    iv8  = 1'b0;
    sew8 = 2'($urandom);
    acc8 = 1'($urandom);
    for (int k = 0; k < 8; k++) pp8[k] = 18'($urandom);
    if (fin) check("out_valid8_latency", {63'd0, ov8}, 64'd1);
    else     check("state8_accum", {62'd0, st8}, {62'd0, ACCUM});
  endtask

  task automatic send16(input logic [1:0] s, input bit a);
    int n;
    sew16 = s;
    acc16 = a;
    for (int k = 0; k < 16; k++) pp16[k] = pps[k];
    iv16 = 1'b1;
    n = 0;
    while (!ir16 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ir16) check("in_ready16_timeout", {63'd0, ir16}, 64'd1);
    @(posedge clk); #1;
    iv16  = 1'b0;
    sew16 = 2'($urandom);
    acc16 = 1'($urandom);
    for (int k = 0; k < 16; k++) pp16[k] = 18'($urandom);
    check("out_valid16_latency", {63'd0, ov16}, 64'd1);
  endtask

  task automatic run_op(input int inst, input logic [1:0] s, input bit a,
                        input logic [31:0] opa, input logic [31:0] opb,
                        input bit has_lit, input logic [63:0] lit);
    logic [63:0] e;
    build_pps(s, opa, opb);
    if (inst == 0) begin
      e = has_lit ? lit : model(prev8, s, a, opa, opb);
      prev8 = e;
      exp_q8.push_back(e);
      if (s == SEW32) begin
        send8(s, a, 0, 1'b0);
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        send8(2'($urandom), 1'($urandom), 8, 1'b1);
      end else begin
        send8(s, a, 0, 1'b1);
      end
    end else begin
      e = has_lit ? lit : model(prev16, s, a, opa, opb);
      prev16 = e;
      exp_q16.push_back(e);
      send16(s, a);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q8.size() != 0 || exp_q16.size() != 0) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q8.size() != 0 || exp_q16.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d/%0d pending required=0", exp_q8.size(), exp_q16.size());
      exp_q8.delete();
      exp_q16.delete();
    end
  endtask

  initial begin
    or8  = 1'b0;
    or16 = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0: begin
          or8  = 1'($urandom);
          or16 = 1'($urandom);
        end
        1: begin
          or8  = 1'b0;
          or16 = 1'b0;
        end
        default: begin
          or8  = 1'b1;
          or16 = 1'b1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset && ov8 && or8) begin
      if (exp_q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result8 actual=%h required=none", res8);
      end else begin
        check("result8", res8, exp_q8.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ov16 && or16) begin
      if (exp_q16.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result16 actual=%h required=none", res16);
      end else begin
        check("result16", res16, exp_q16.pop_front());
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    iv8 = 1'b0; sew8 = 2'b00; acc8 = 1'b0; pp8 = '0;
    iv16 = 1'b0; sew16 = 2'b00; acc16 = 1'b0; pp16 = '0;
    prev8 = '0;
    prev16 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_result8", res8, 64'd0);
    check("reset_out_valid8", {63'd0, ov8}, 64'd0);
    check("reset_in_ready8", {63'd0, ir8}, 64'd1);
    check("reset_state8", {62'd0, st8}, {62'd0, IDLE});
    check("reset_result16", res16, 64'd0);

    bp_mode = 2;
    run_op(0, SEW32, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    run_op(0, SEW32, 1'b0, 32'hFFFF_FFFB, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(1, SEW32, 1'b0, 32'hFFFF_FFFB, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(0, SEW8, 1'b0, {8'd5, 8'hFF, 8'h80, 8'd127}, {8'hFD, 8'd2, 8'h80, 8'd127},
           1'b1, 64'hFFF1_FFFE_4000_3F01);
    run_op(1, SEW8, 1'b0, {8'd5, 8'hFF, 8'h80, 8'd127}, {8'hFD, 8'd2, 8'h80, 8'd127},
           1'b1, 64'hFFF1_FFFE_4000_3F01);
    run_op(0, SEW16, 1'b0, {16'd300, 16'h8000}, {16'hFFFE, 16'h8000},
           1'b1, 64'hFFFF_FDA8_4000_0000);
    run_op(1, SEW16, 1'b0, {16'd300, 16'h8000}, {16'hFFFE, 16'h8000},
           1'b1, 64'hFFFF_FDA8_4000_0000);
    run_op(0, 2'b11, 1'b1, $urandom, $urandom, 1'b1, 64'd0);
    drain();

    // Held-off result must stay frozen and block new beats.
    bp_mode = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    run_op(0, SEW8, 1'b0, 32'd3, 32'd4, 1'b1, 64'd12);
    n = 0;
    while (!ov8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int c = 0; c < 3; c++) begin
      check("stall_result8", res8, 64'd12);
      check("stall_in_ready8", {63'd0, ir8}, 64'd0);
      check("stall_out_valid8", {63'd0, ov8}, 64'd1);
      @(posedge clk); #1;
    end
    bp_mode = 2;
    run_op(0, SEW8, 1'b1, 32'd3, 32'd4, 1'b1, 64'd24);
    drain();

    // Reset between the two beats of a sew32 op discards it.
    build_pps(SEW32, 32'd7, 32'd6);
    send8(SEW32, 1'b0, 0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midop_reset_out_valid8", {63'd0, ov8}, 64'd0);
    check("midop_reset_state8", {62'd0, st8}, {62'd0, IDLE});
    check("midop_reset_in_ready8", {63'd0, ir8}, 64'd1);
    prev8  = '0;
    prev16 = '0;
    run_op(0, SEW32, 1'b0, 32'd7, 32'd6, 1'b1, 64'd42);
    run_op(0, SEW32, 1'b1, 32'd7, 32'd6, 1'b1, 64'd84);
    drain();

    bp_mode = 0;
    for (int i = 0; i < 40; i++)
      run_op(0, 2'($urandom_range(0, 2)), 1'($urandom), $urandom, $urandom, 1'b0, 64'd0);
    for (int i = 0; i < 25; i++)
      run_op(1, 2'($urandom_range(0, 2)), 1'($urandom), $urandom, $urandom, 1'b0, 64'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
